fft_stage_sequencer: RTL and testbench

//  Top-level sequencer for the in-place radix-2 FFT engine. Runs one transform per start_fft:
//  bit-reversed load phase, SIZE butterfly stages, then the output phase. Each stage is started

---
 rtl/fft_stage_sequencer_if.sv | 31 +++
 rtl/fft_stage_sequencer.sv | 154 +++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_sequencer_if.sv
// Control interface for the radix-2 FFT stage sequencer.
// The master side issues start_fft and returns the loader / address generator /
// output reader completion pulses; the slave side is the sequencer itself.
interface fft_stage_sequencer_if #(
   parameter int SIZE = 4
);
   logic            start_fft;
   logic            load_done;
   logic            stage_done;
   logic            out_done;
   logic            start_load;
   logic            start_stage;
   logic [SIZE-1:0] stage_num;
   logic            bank_sel;
   logic            start_output;
   logic            busy;
   logic            fft_done;
   logic            seq_err;

   modport master (
      output start_fft, load_done, stage_done, out_done,
      input  start_load, start_stage, stage_num, bank_sel,
             start_output, busy, fft_done, seq_err
   );

   modport slave (
      input  start_fft, load_done, stage_done, out_done,
      output start_load, start_stage, stage_num, bank_sel,
             start_output, busy, fft_done, seq_err
   );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Top-level sequencer for the in-place radix-2 FFT engine.
// One transform per accepted start_fft: bit-reversed load, SIZE butterfly stages
// (each followed by a pipeline-drain gap), then the output phase. Only control
// pulses, the stage index and the ping-pong bank select are produced here.
module fft_stage_sequencer #(
   parameter int N          = 16,
   parameter int SIZE       = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fft_stage_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STAGE_START,
      STAGE_RUN,
      GAP,
      OUTPUT,
      DONE
   } state_t;

   localparam logic [SIZE-1:0] LAST_STAGE = SIZE[SIZE-1:0];
   localparam logic [SIZE-1:0] FIRST_STAGE = 1;
   localparam logic [3:0]      GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   // Reject parameter sets where the stage count does not match the transform length
   // or the drain gap does not fit the 4-bit gap counter.
   if ((N != (1 << SIZE)) || (SIZE < 2) || (GAP_CYCLES < 0) || (GAP_CYCLES > 15)) begin : g_param_check
      $error("fft_stage_sequencer: illegal N/SIZE/GAP_CYCLES combination");
   end

   state_t          state;
   logic [3:0]      gap_cnt;
   logic            start_load_r;
   logic            start_stage_r;
   logic [SIZE-1:0] stage_num_r;
   logic            bank_sel_r;
   logic            start_output_r;
   logic            busy_r;
   logic            fft_done_r;
   logic            seq_err_r;

   logic accept_start;
   logic stage_wait;
   logic stray;
   logic advance;

   // A stage_done arriving in the start_stage cycle is as good as one in STAGE_RUN.
   assign accept_start = (state == IDLE) && bus.start_fft;
   assign stage_wait   = (state == STAGE_START) || (state == STAGE_RUN);

   // Any completion pulse that does not belong to the current wait state is a protocol error.
   assign stray = (bus.load_done  && (state != LOAD))
               || (bus.stage_done && !stage_wait)
               || (bus.out_done   && (state != OUTPUT));

   // Move on to the next stage (or the output phase) once the drain gap has elapsed;
   // with no gap this happens straight off the accepted stage_done.
   assign advance = (stage_wait && bus.stage_done && (GAP_CYCLES == 0))
                 || ((state == GAP) && (gap_cnt == 4'd0));

   // Main sequencing FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         gap_cnt        <= 4'd0;
         start_load_r   <= 1'b0;
         start_stage_r  <= 1'b0;
         stage_num_r    <= '0;
         bank_sel_r     <= 1'b0;
         start_output_r <= 1'b0;
         busy_r         <= 1'b0;
         fft_done_r     <= 1'b0;
         seq_err_r      <= 1'b0;
      end else begin
         start_load_r   <= 1'b0;
         start_stage_r  <= 1'b0;
         start_output_r <= 1'b0;
         fft_done_r     <= 1'b0;
         seq_err_r      <= (seq_err_r && !accept_start) || stray;

         case (state)
            IDLE: begin
               if (bus.start_fft) begin
                  state        <= LOAD;
                  start_load_r <= 1'b1;
                  busy_r       <= 1'b1;
                  bank_sel_r   <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.load_done) begin
                  state         <= STAGE_START;
                  start_stage_r <= 1'b1;
                  stage_num_r   <= FIRST_STAGE;
               end
            end
            STAGE_START, STAGE_RUN: begin
               if (state == STAGE_START) begin
                  state <= STAGE_RUN;
               end
               if (bus.stage_done) begin
                  bank_sel_r <= ~bank_sel_r;
                  state      <= GAP;
                  gap_cnt    <= GAP_LAST;
               end
            end
            GAP: begin
               if (gap_cnt != 4'd0) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            OUTPUT: begin
               if (bus.out_done) begin
                  state      <= DONE;
                  fft_done_r <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (advance) begin
            if (stage_num_r != LAST_STAGE) begin
               stage_num_r   <= stage_num_r + FIRST_STAGE;
               start_stage_r <= 1'b1;
               state         <= STAGE_START;
            end else begin
               stage_num_r    <= '0;
               start_output_r <= 1'b1;
               state          <= OUTPUT;
            end
         end
      end
   end

   assign bus.start_load   = start_load_r;
   assign bus.start_stage  = start_stage_r;
   assign bus.stage_num    = stage_num_r;
   assign bus.bank_sel     = bank_sel_r;
   assign bus.start_output = start_output_r;
   assign bus.busy         = busy_r;
   assign bus.fft_done     = fft_done_r;
   assign bus.seq_err      = seq_err_r;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer: two instances (drain gap 2 and gap 0) share
// one stimulus stream; every cycle both are compared against a schedule-based
// reference model, plus a scripted vector table and hand-written corner cases.
module tb_fft_stage_sequencer;

   localparam int SIZE = 4;

   localparam int P_IDLE   = 0;
   localparam int P_LOAD   = 1;
   localparam int P_STAGE  = 2;
   localparam int P_WAIT   = 3;
   localparam int P_OUT    = 4;
   localparam int P_FINISH = 5;

   typedef struct packed {
      logic       sl;
      logic       ss;
      logic [3:0] sn;
      logic       bk;
      logic       so;
      logic       busy;
      logic       done;
      logic       err;
   } outs_t;

   typedef struct {
      logic  sf;
      logic  ld;
      logic  sd;
      logic  od;
      outs_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int failures = 0;

   outs_t act [2];
   outs_t exp_o [2];
   int    phase [2];
   int    resume_at [2];
   int    gaps [2] = '{2, 0};
   int    cyc = 0;

   vec_t  vecs [24];

   int xf_ss [3][4];
   int xf_nss [3];
   int xf_so [3];
   int xf_done [3];

   fft_stage_sequencer_if #(.SIZE(SIZE)) bus0 ();
   fft_stage_sequencer_if #(.SIZE(SIZE)) bus1 ();

   fft_stage_sequencer #(.N(16), .SIZE(SIZE), .GAP_CYCLES(2)) u_dut_gap2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   fft_stage_sequencer #(.N(16), .SIZE(SIZE), .GAP_CYCLES(0)) u_dut_gap0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   assign act[0] = {bus0.start_load, bus0.start_stage, bus0.stage_num, bus0.bank_sel,
                    bus0.start_output, bus0.busy, bus0.fft_done, bus0.seq_err};
   assign act[1] = {bus1.start_load, bus1.start_stage, bus1.stage_num, bus1.bank_sel,
                    bus1.start_output, bus1.busy, bus1.fft_done, bus1.seq_err};

   // Hard stop in case something wedges the stimulus loops.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no end, required $finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mk(input logic sf, ld, sd, od, sl, ss, input int sn,
                               input logic bk, so, busy, done, err);
      vec_t v;
      v.sf = sf; v.ld = ld; v.sd = sd; v.od = od;
      v.exp.sl = sl; v.exp.ss = ss; v.exp.sn = 4'(sn); v.exp.bk = bk;
      v.exp.so = so; v.exp.busy = busy; v.exp.done = done; v.exp.err = err;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         exp_o[i]     = '0;
         phase[i]     = P_IDLE;
         resume_at[i] = -1;
      end
   endtask

   // Reference model: tracks which handshake is awaited and schedules the next
   // stage / output start at an absolute edge index derived from the drain gap.
   task automatic model_step(input int i, input logic sf, ld, sd, od);
      outs_t n;
      logic  bad;
      n = exp_o[i];
      n.sl = 1'b0; n.ss = 1'b0; n.so = 1'b0; n.done = 1'b0;
      bad = (ld && phase[i] != P_LOAD) || (sd && phase[i] != P_STAGE)
         || (od && phase[i] != P_OUT);
      case (phase[i])
         P_IDLE: if (sf) begin
            phase[i] = P_LOAD; n.sl = 1'b1; n.busy = 1'b1; n.bk = 1'b0; n.err = 1'b0;
         end
         P_LOAD: if (ld) begin
            phase[i] = P_STAGE; n.ss = 1'b1; n.sn = 4'd1;
         end
         P_STAGE: if (sd) begin
            n.bk = ~n.bk; phase[i] = P_WAIT; resume_at[i] = cyc + gaps[i];
         end
         P_OUT: if (od) begin
            phase[i] = P_FINISH; n.done = 1'b1; resume_at[i] = cyc + 1;
         end
         default: ;
      endcase
      if (phase[i] == P_WAIT && resume_at[i] == cyc) begin
         if (int'(n.sn) < SIZE) begin
            n.sn = n.sn + 4'd1; n.ss = 1'b1; phase[i] = P_STAGE;
         end else begin
            n.sn = 4'd0; n.so = 1'b1; phase[i] = P_OUT;
         end
      end else if (phase[i] == P_FINISH && resume_at[i] == cyc) begin
         phase[i] = P_IDLE; n.busy = 1'b0;
      end
      if (bad) n.err = 1'b1;
      exp_o[i] = n;
   endtask

   task automatic check_output(input string name, input int i);
      checks++;
      if (act[i] !== exp_o[i]) begin
         failures++;
         $display("[TB] FAIL %s inst%0d cyc%0d: got %b required %b (sl ss sn bk so busy done err)",
                  name, i, cyc, act[i], exp_o[i]);
      end
   endtask

   task automatic check_val(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("[TB] FAIL %s: got %0d required %0d", name, got, want);
      end
   endtask

   // Called just after a falling edge: drive inputs, advance the model, compare after the rising edge.
   task automatic apply_stimulus(input logic sf, ld, sd, od);
      bus0.start_fft = sf; bus0.load_done = ld; bus0.stage_done = sd; bus0.out_done = od;
      bus1.start_fft = sf; bus1.load_done = ld; bus1.stage_done = sd; bus1.out_done = od;
      model_step(0, sf, ld, sd, od);
      model_step(1, sf, ld, sd, od);
      cyc++;
      @(posedge clk);
      #1;
      check_output("model", 0);
      check_output("model", 1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      apply_idle_inputs();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_output("reset", 0);
      check_output("reset", 1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic apply_idle_inputs();
      bus0.start_fft = 1'b0; bus0.load_done = 1'b0; bus0.stage_done = 1'b0; bus0.out_done = 1'b0;
      bus1.start_fft = 1'b0; bus1.load_done = 1'b0; bus1.stage_done = 1'b0; bus1.out_done = 1'b0;
   endtask

   // Answer every pulse of the gap-2 instance in the same cycle it appears, recording pulse times.
   task automatic run_xfer(input bit issue_start, input int r);
      int  k;
      bit  done_seen;
      done_seen = 1'b0;
      xf_nss[r] = 0; xf_so[r] = -1; xf_done[r] = -1;
      for (int j = 0; j < 4; j++) xf_ss[r][j] = -1;
      if (issue_start) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
         check_val("start_load_on_accept", int'(act[0].sl), 1);
         check_val("start_clears_seq_err", int'(act[0].err), 0);
      end
      k = 1;
      while (!done_seen && k < 200) begin
         if (act[0].ss) begin
            if (xf_nss[r] < 4) xf_ss[r][xf_nss[r]] = k;
            xf_nss[r]++;
         end
         if (act[0].so) xf_so[r] = k;
         if (act[0].done) begin
            xf_done[r] = k;
            done_seen = 1'b1;
         end else begin
            apply_stimulus(1'b0, act[0].sl, act[0].ss, act[0].so);
            k++;
         end
      end
      if (!done_seen) begin
         failures++;
         checks++;
         $display("[TB] FAIL xfer_timeout run%0d: got no fft_done, required fft_done within 200 cycles", r);
      end
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("busy_drops_after_done", int'(act[0].busy), 0);
   endtask

   initial begin
      int k;
      apply_idle_inputs();
      model_reset();

      vecs[0]  = mk(1,0,0,0, 1,0,0,0,0,1,0,0);
      vecs[1]  = mk(0,0,0,0, 0,0,0,0,0,1,0,0);
      vecs[2]  = mk(0,1,0,0, 0,1,1,0,0,1,0,0);
      vecs[3]  = mk(0,0,0,0, 0,0,1,0,0,1,0,0);
      vecs[4]  = mk(0,0,1,0, 0,0,1,1,0,1,0,0);
      vecs[5]  = mk(0,0,0,0, 0,0,1,1,0,1,0,0);
      vecs[6]  = mk(0,0,0,0, 0,1,2,1,0,1,0,0);
      vecs[7]  = mk(1,0,1,0, 0,0,2,0,0,1,0,0);
      vecs[8]  = mk(0,0,0,0, 0,0,2,0,0,1,0,0);
      vecs[9]  = mk(0,0,0,0, 0,1,3,0,0,1,0,0);
      vecs[10] = mk(0,0,0,0, 0,0,3,0,0,1,0,0);
      vecs[11] = mk(0,0,1,0, 0,0,3,1,0,1,0,0);
      vecs[12] = mk(0,0,0,0, 0,0,3,1,0,1,0,0);
      vecs[13] = mk(0,0,0,0, 0,1,4,1,0,1,0,0);
      vecs[14] = mk(0,0,1,0, 0,0,4,0,0,1,0,0);
      vecs[15] = mk(0,0,0,0, 0,0,4,0,0,1,0,0);
      vecs[16] = mk(0,0,0,0, 0,0,0,0,1,1,0,0);
      vecs[17] = mk(0,0,0,0, 0,0,0,0,0,1,0,0);
      vecs[18] = mk(0,0,0,1, 0,0,0,0,0,1,1,0);
      vecs[19] = mk(1,0,0,0, 0,0,0,0,0,0,0,0);
      vecs[20] = mk(1,0,0,0, 1,0,0,0,0,1,0,0);
      vecs[21] = mk(0,0,1,0, 0,0,0,0,0,1,0,1);
      vecs[22] = mk(0,0,0,0, 0,0,0,0,0,1,0,1);
      vecs[23] = mk(0,1,0,0, 0,1,1,0,0,1,0,1);

      // Power-on reset.
      @(posedge clk);
      #1;
      check_output("reset", 0);
      check_output("reset", 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Scripted full transform on the gap-2 instance.
      for (int v = 0; v < 24; v++) begin
         apply_stimulus(vecs[v].sf, vecs[v].ld, vecs[v].sd, vecs[v].od);
         checks++;
         if (act[0] !== vecs[v].exp) begin
            failures++;
            $display("[TB] FAIL vec[%0d]: got %b required %b (sl ss sn bk so busy done err)",
                     v, act[0], vecs[v].exp);
         end
      end

      // Stage-to-stage latency with and without a drain gap.
      do_reset();
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("gap0_start_stage_t+1", int'(act[1].ss), 1);
      check_val("gap0_stage_num", int'(act[1].sn), 2);
      check_val("gap2_no_start_t+1", int'(act[0].ss), 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("gap2_no_start_t+2", int'(act[0].ss), 0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("gap2_start_stage_t+3", int'(act[0].ss), 1);
      check_val("gap2_stage_num", int'(act[0].sn), 2);

      // Stray stage_done in LOAD, then finish the run and show a new start clears seq_err.
      do_reset();
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("stray_sets_seq_err", int'(act[0].err), 1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("still_in_load", int'(act[0].ss), 1);
      run_xfer(1'b0, 0);

      // Two back-to-back zero-latency transforms.
      run_xfer(1'b1, 1);
      run_xfer(1'b1, 2);
      for (int r = 1; r < 3; r++) begin
         check_val($sformatf("b2b%0d_stage_count", r), xf_nss[r], 4);
         for (int j = 0; j < 4; j++)
            check_val($sformatf("b2b%0d_stage%0d_cycle", r, j + 1), xf_ss[r][j], 2 + 3 * j);
         check_val($sformatf("b2b%0d_output_cycle", r), xf_so[r], 14);
         check_val($sformatf("b2b%0d_done_cycle", r), xf_done[r], 15);
      end
      check_val("b2b_no_seq_err", int'(act[0].err), 0);

      // Asynchronous reset in the middle of stage 3.
      do_reset();
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      k = 0;
      while (!(act[0].ss && act[0].sn == 4'd3) && k < 50) begin
         apply_stimulus(1'b0, act[0].sl, act[0].ss, act[0].so);
         k++;
      end
      check_val("reached_stage3", int'(act[0].sn), 3);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_val("async_reset_outputs", int'(act[0]), 0);
      check_output("async_reset", 1);
      @(posedge clk);
      #1;
      check_output("reset_held", 0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("late_stage_done_seq_err", int'(act[0].err), 1);
      check_val("late_stage_done_no_start", int'(act[0].ss), 0);

      // Randomized traffic, including stray pulses and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            apply_stimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
